// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory sequencer/arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_DEPTH_WORDS = 64;

  // Word-aligned and inside [base, base + 4*depth), unsigned 32-bit compare.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] lim;
    lim = base + (depth << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr < lim);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the cpu, dma and memory-side signals around dmem_arbiter.
interface dmem_arbiter_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_freeze;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        dma_err;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err, cpu_freeze,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack, dma_err,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_freeze,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack, dma_err,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; ptr names the port favoured on the next tie.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  owner_t     served,
  output logic [1:0] grant,
  output owner_t     ptr
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (ptr == OWN_DMA) ? 2'b10 : 2'b01;
  end

  // After serving a port, the other one wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= OWN_CPU;
    else if (update) ptr <= (served == OWN_CPU) ? OWN_DMA : OWN_CPU;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Wait-state sequencer and cpu/dma arbiter in front of the data memory.
// Define DMEM_ARB_DMA_EN to enable the dma port; otherwise cpu always owns it.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_t      state, state_n;
  logic [3:0]  cnt;
  owner_t      owner_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, err_q;

  logic        cpu_req, dma_req, resp, start;
  logic [1:0]  grant;
  logic        sel_dma, sel_we, sel_ok;
  logic [31:0] sel_addr, sel_wdata;
  owner_t      unused_rr_ptr;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;
  assign resp    = (state == RESP);

`ifdef DMEM_ARB_DMA_EN
  assign dma_req       = bus.dma_req;
  assign bus.dma_ack   = resp & (owner_q == OWN_DMA);
  assign bus.dma_err   = bus.dma_ack & err_q;
  assign bus.dma_rdata = bus.dma_ack ? rdata_q : 32'd0;
`else
  logic unused_dma_req;
  assign unused_dma_req = bus.dma_req;
  assign dma_req        = 1'b0;
  assign bus.dma_ack    = 1'b0;
  assign bus.dma_err    = 1'b0;
  assign bus.dma_rdata  = 32'd0;
`endif

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({dma_req, cpu_req}),
    .update (resp),
    .served (owner_q),
    .grant  (grant),
    .ptr    (unused_rr_ptr)
  );

  // A cpu rd+wr pair is treated as a write.
  assign sel_dma   = grant[1];
  assign sel_addr  = sel_dma ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = sel_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign sel_we    = sel_dma ? bus.dma_we    : bus.cpu_wr;
  assign sel_ok    = addr_in_range(sel_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign start     = (state == IDLE) && (grant != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = sel_ok ? ACCESS : RESP;
      ACCESS:  if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Transaction fields are frozen in IDLE so later request changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      owner_q <= OWN_CPU;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (start) begin
      cnt     <= 4'(WAIT_CYCLES - 1);
      owner_q <= sel_dma ? OWN_DMA : OWN_CPU;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      rdata_q <= 32'd0;
      we_q    <= sel_we;
      err_q   <= ~sel_ok;
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else if (!we_q)  rdata_q <= bus.mem_rdata;
    end
  end

  // Memory strobes decode straight from state so an async reset kills them at once.
  assign bus.mem_rd    = (state == ACCESS) & ~we_q;
  assign bus.mem_wr    = (state == ACCESS) & we_q & (cnt == 4'd0);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ready  = resp & (owner_q == OWN_CPU);
  assign bus.cpu_err    = bus.cpu_ready & err_q;
  assign bus.cpu_rdata  = bus.cpu_ready ? rdata_q : 32'd0;
  assign bus.cpu_freeze = cpu_req & ~bus.cpu_ready;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 64-word memory model at byte base 1024.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    bit          port;
    int          cyc;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.WAIT_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];
  logic [5:0]  mem_idx;
  assign mem_idx       = 6'((bus.mem_addr - 32'd1024) >> 2);
  assign bus.mem_rdata = mem[mem_idx];
  always @(posedge clk) if (bus.mem_wr) mem[mem_idx] <= bus.mem_wdata;

  int   cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  int   n_wr, n_rd, wr_cyc, first_rd, last_rd, n_dma_ack, last_t0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_wr = 0; n_rd = 0; wr_cyc = -1; first_rd = -1; last_rd = -1;
  endtask

  // Memory-side activity and response monitor share the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wr) begin n_wr++; wr_cyc = cyc; end
      if (bus.mem_rd) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (bus.dma_ack) n_dma_ack++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   p;
    if (!rst && (bus.cpu_ready || bus.dma_ack)) begin
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp: cpu_ready=%0b dma_ack=%0b with nothing expected (cycle %0d)",
                 bus.cpu_ready, bus.dma_ack, cyc);
      end else begin
        e = sbq.pop_front();
        p = bus.dma_ack;
        chk("resp_both", {31'd0, bus.cpu_ready & bus.dma_ack}, 32'd0);
        chk("resp_port", {31'd0, p}, {31'd0, e.port});
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", {31'd0, p ? bus.dma_err : bus.cpu_err}, {31'd0, e.err});
        chk("resp_rdata", p ? bus.dma_rdata : bus.cpu_rdata, e.rdata);
        chk("nonowner_rdata", p ? bus.cpu_rdata : bus.dma_rdata, 32'd0);
      end
    end
  end

  task automatic txn(input bit port, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int lat, input bit err, input logic [31:0] rdata);
    exp_t e;
    bit   seen;
    @(negedge clk);
    last_t0 = cyc;
    if (!port) begin
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.dma_req = 1'b1; bus.dma_we = wr; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end
    e.port = port; e.cyc = last_t0 + lat; e.err = err; e.rdata = rdata;
    sbq.push_back(e);
    if (!port) begin #1; chk("freeze_hi", {31'd0, bus.cpu_freeze}, 32'd1); end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port ? bus.dma_ack : bus.cpu_ready;
    end
    if (!seen) begin
      failures++;
      $display("FAIL txn_timeout: port %0d addr 0x%08h no completion, required one", port, addr);
    end else if (!port) chk("freeze_lo", {31'd0, bus.cpu_freeze}, 32'd0);
    if (!port) begin bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; end
    else       bus.dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    mem[1]  <= 32'h12345678;
    mem[63] <= 32'hA5A50063;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    n_dma_ack = 0;
    clr_stats();

    repeat (2) @(negedge clk);
    chk("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("rst_cpu_err", {31'd0, bus.cpu_err}, 32'd0);
    chk("rst_dma_ack", {31'd0, bus.dma_ack}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    clr_stats();
    txn(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4, 1'b0, 32'd0);
    chk("wr_mem0", mem[0], 32'hDEADBEEF);
    chk("wr_count", n_wr, 32'd1);
    chk("wr_cycle", wr_cyc, last_t0 + 3);
    chk("wr_no_rd", n_rd, 32'd0);

    clr_stats();
    txn(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 4, 1'b0, 32'h12345678);
    chk("rd_count", n_rd, 32'd3);
    chk("rd_first", first_rd, last_t0 + 1);
    chk("rd_last", last_rd, last_t0 + 3);

    clr_stats();
    txn(1'b0, 1'b1, 1'b0, 32'd1280, 32'd0, 1, 1'b1, 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'd1026, 32'd0, 1, 1'b1, 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'd1020, 32'd0, 1, 1'b1, 32'd0);
    chk("err_no_mem", n_rd + n_wr, 32'd0);

    txn(1'b0, 1'b1, 1'b0, 32'd1276, 32'd0, 4, 1'b0, 32'hA5A50063);

    clr_stats();
    txn(1'b0, 1'b1, 1'b1, 32'd1036, 32'h0BADCAFE, 4, 1'b0, 32'd0);
    chk("rdwr_mem3", mem[3], 32'h0BADCAFE);
    chk("rdwr_no_rd", n_rd, 32'd0);

    // Reset lands in the middle of a write window.
    clr_stats();
    @(negedge clk);
    bus.cpu_wr = 1'b1; bus.cpu_addr = 32'd1032; bus.cpu_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.cpu_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_wr", n_wr, 32'd0);
    chk("rstmid_mem2", mem[2], 32'd0);
    chk("rstmid_state", {30'd0, dut.state}, {30'd0, IDLE});

`ifdef DMEM_ARB_DMA_EN
    begin
      exp_t e;
      int   t0, seen;
      @(negedge clk);
      t0 = cyc;
      bus.cpu_rd = 1'b1; bus.cpu_addr = 32'd1028;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'd1276;
      e.err = 1'b0;
      e.port = 0; e.cyc = t0 + 4;  e.rdata = 32'h12345678; sbq.push_back(e);
      e.port = 1; e.cyc = t0 + 9;  e.rdata = 32'hA5A50063; sbq.push_back(e);
      e.port = 0; e.cyc = t0 + 14; e.rdata = 32'h12345678; sbq.push_back(e);
      e.port = 1; e.cyc = t0 + 19; e.rdata = 32'hA5A50063; sbq.push_back(e);
      seen = 0;
      for (int i = 0; i < 60 && seen < 4; i++) begin
        @(negedge clk);
        if (bus.cpu_ready || bus.dma_ack) seen++;
      end
      bus.cpu_rd = 1'b0; bus.dma_req = 1'b0;
      chk("both_resp_count", seen, 32'd4);
    end

    clr_stats();
    txn(1'b1, 1'b0, 1'b1, 32'd1044, 32'h5555AAAA, 4, 1'b0, 32'd0);
    chk("dma_wr_mem5", mem[5], 32'h5555AAAA);
    chk("dma_wr_count", n_wr, 32'd1);
    txn(1'b1, 1'b0, 1'b0, 32'd2000, 32'd0, 1, 1'b1, 32'd0);
`else
    n_dma_ack = 0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'd1024;
    txn(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 4, 1'b0, 32'h12345678);
    txn(1'b0, 1'b0, 1'b1, 32'd1040, 32'h77778888, 4, 1'b0, 32'd0);
    chk("nodma_mem4", mem[4], 32'h77778888);
    chk("nodma_rdata", bus.dma_rdata, 32'd0);
    bus.dma_req = 1'b0;
    chk("nodma_ack_count", n_dma_ack, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
